cpu_sys_ctrl: RTL and testbench
===============================

Name: cpu_sys_ctrl

Overview:
Parametrised CPU clock-enable and reset sequencer for the Apple-1 core, generalising the fixed divide-by-25 strobe and 6-bit power-up reset counter. Drives the 6502 RDY/clock-enable and active-high reset. Adds:
- a turbo mode (one enable per clock)
- a wait-state hold input for slow peripherals
- a soft-reset request
- a retired-cycle counter for profiling

Parameters:
CLK_DIV, 25, clock-enable divisor in normal mode (>=2); one cpu_clken every CLK_DIV clocks.
RST_CYCLES, 63, number of cpu_clken pulses cpu_reset stays high after reset or soft reset (>=1).
CNT_W, 32, width of cpu_cycles.

Ports:
clk25  input  1  master clock
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
soft_reset  input  1  one-cycle request to re-run the CPU reset sequence
turbo  input  1  1 = period of 1 clock, 0 = period of CLK_DIV clocks
hold  input  1  wait-state request; stalls the next enable while high
step_mode  input  1  single-step enable (used only with SINGLE_STEP_EN)
step  input  1  step request, rising-edge sensitive (used only with SINGLE_STEP_EN)
cpu_clken  output  1  registered one-clock enable strobe to the CPU and bus latches
cpu_reset  output  1  registered active-high CPU reset
cpu_cycles  output  CNT_W  count of enables delivered while cpu_reset is low

Behaviour:
- Reset values: div_cnt=0, per_sel=0 (normal), rst_cnt=0, cpu_clken=0, cpu_reset=1, cpu_cycles=0.
- per_sel: latches turbo only in cycles where div_cnt==0.
  - A turbo change mid-period takes effect at the next period boundary.
  - period = per_sel ? 1 : CLK_DIV.
- tick is combinational: tick = (div_cnt==0) & ~hold & step_ok.
  - step_ok = 1 without the optional feature.
- div_cnt:
  - If div_cnt==0 and tick==0, div_cnt holds at 0 (stall).
  - Otherwise div_cnt <= (div_cnt==period-1) ? 0 : div_cnt+1.
  - hold has no effect while div_cnt != 0.
- cpu_clken <= tick. The strobe is one clock wide and one clock after the tick decision.
- Enable period is CLK_DIV clocks in normal mode and 1 clock in turbo mode. Each clock of stall adds one clock to the period.
- Reset sequencer, on tick:
  - rst_cnt <= rst_cnt + (rst_cnt != RST_CYCLES), saturating.
  - cpu_reset <= (rst_cnt != RST_CYCLES), using the pre-update value.
  - Result: CPU enable pulses 1..RST_CYCLES see cpu_reset=1. Pulse RST_CYCLES+1 coincides with cpu_reset falling.
- soft_reset=1, next clock:
  - rst_cnt=0, cpu_reset=1, cpu_cycles=0.
  - div_cnt and cpu_clken are undisturbed.
  - If coincident with a tick, soft_reset wins for rst_cnt/cpu_reset; cpu_clken still pulses.
- cpu_cycles:
  - Increments by 1 in every clock where cpu_clken==1 and cpu_reset==0 (registered outputs).
  - Wraps modulo 2^CNT_W.
- reset overrides soft_reset, hold and step in all cases.
- reset asserted mid-period returns all state to reset values on the next edge, with no partial strobe.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - A step rising edge (step high, registered step low) sets step_pend.
  - step_ok = ~step_mode | cpu_reset | step_pend.
  - step_pend clears on the tick that consumes it.
  - A new edge in the same cycle as consumption keeps step_pend set.
  - The reset sequence always runs freely.
- Not defined: step_mode and step are ignored, step_ok=1, and no step registers are built.

Test Plan:
1. Release reset, turbo=0, hold=0 (defaults) -> cpu_clken pulses exactly every 25 clocks. cpu_reset is high for pulses 1-63 and falls with pulse 64. cpu_cycles=1 one clock after pulse 64 and=10 after pulse 73.
2. After the reset sequence, set turbo=1 mid-period -> the period stays 25 until div_cnt returns to 0, then cpu_clken is high every clock. Clearing turbo restores 25-clock spacing after the next boundary.
3. Hold high for 10 clocks starting 3 clocks before a boundary -> the enable interval is 25+7=32 clocks. hold high only while div_cnt != 0 -> interval is unchanged at 25.
4. soft_reset pulse at cpu_cycles=100 -> next clock cpu_reset=1 and cpu_cycles=0. 63 further pulses occur with reset high; reset falls on pulse 64; counting resumes.
5. soft_reset coincident with a tick -> cpu_clken still pulses, rst_cnt=0, cpu_reset=1. Reset asserted mid-period -> all outputs at reset values next clock.
6. SINGLE_STEP_EN, step_mode=1 after the reset sequence -> no enables. Each step rising edge yields exactly one cpu_clken at the next div_cnt==0. Two edges before one boundary yield a single pulse.

Source files
------------

// File: rtl/cpu_sys_ctrl.sv
// cpu_sys_ctrl: CPU clock-enable and reset sequencer for the Apple-1 6502 core.
// Generates a one-clock cpu_clken strobe every CLK_DIV clocks, or every clock
// in turbo mode. Wait-states from hold stretch the period. The CPU reset stays
// high for RST_CYCLES enables after reset or soft_reset. Enables delivered
// outside reset are counted in cpu_cycles.
// Optional feature macro: SINGLE_STEP_EN adds step_mode/step single stepping.
// When the macro is undefined, step_mode and step are ignored.
module cpu_sys_ctrl #(
  parameter int CLK_DIV    = 25,
  parameter int RST_CYCLES = 63,
  parameter int CNT_W      = 32
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             turbo,
  input  logic             hold,
  input  logic             step_mode,
  input  logic             step,
  output logic             cpu_clken,
  output logic             cpu_reset,
  output logic [CNT_W-1:0] cpu_cycles
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             per_sel_q, per_sel_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             cpu_clken_q, cpu_clken_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [CNT_W-1:0] cpu_cycles_q, cpu_cycles_d;
  logic             at_bound;
  logic             tick;
  logic             step_ok;

`ifdef SINGLE_STEP_EN
  logic step_q, step_d;
  logic step_pend_q, step_pend_d;

  // Single-step gating: a rising step edge arms one enable; reset runs freely.
  always_comb begin
    step_d      = step;
    step_ok     = ~step_mode | cpu_reset_q | step_pend_q;
    step_pend_d = step_pend_q;
    if (step & ~step_q) begin
      step_pend_d = 1'b1;
    end else if (tick) begin
      step_pend_d = 1'b0;
    end
  end

  // Step edge detector and pending-step flag.
  always_ff @(posedge clk25) begin
    if (reset) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= step_d;
      step_pend_q <= step_pend_d;
    end
  end
`else
  logic unused_step;
  assign unused_step = &{1'b0, step_mode, step};
  assign step_ok     = 1'b1;
`endif

  // Period counter: stalls at zero until an enable is allowed, then counts
  // out one period. turbo is sampled only at the period boundary.
  always_comb begin
    at_bound  = (div_cnt_q == '0);
    tick      = at_bound & ~hold & step_ok;
    per_sel_d = at_bound ? turbo : per_sel_q;
    div_cnt_d = div_cnt_q;
    if (!at_bound || tick) begin
      if (per_sel_d || (div_cnt_q == DIV_LAST)) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  // Reset sequencer and cycle counter; soft_reset restarts the sequence
  // without disturbing the enable timing.
  always_comb begin
    cpu_clken_d  = tick;
    rst_cnt_d    = rst_cnt_q;
    cpu_reset_d  = cpu_reset_q;
    cpu_cycles_d = cpu_cycles_q;
    if (cpu_clken_q && !cpu_reset_q) begin
      cpu_cycles_d = cpu_cycles_q + CNT_W'(1);
    end
    if (soft_reset) begin
      rst_cnt_d    = '0;
      cpu_reset_d  = 1'b1;
      cpu_cycles_d = '0;
    end else if (tick) begin
      cpu_reset_d = (rst_cnt_q != RC_LAST);
      if (rst_cnt_q != RC_LAST) begin
        rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
    end
  end

  // State registers; reset forces the CPU into reset with no strobe.
  always_ff @(posedge clk25) begin
    if (reset) begin
      div_cnt_q    <= '0;
      per_sel_q    <= 1'b0;
      rst_cnt_q    <= '0;
      cpu_clken_q  <= 1'b0;
      cpu_reset_q  <= 1'b1;
      cpu_cycles_q <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      per_sel_q    <= per_sel_d;
      rst_cnt_q    <= rst_cnt_d;
      cpu_clken_q  <= cpu_clken_d;
      cpu_reset_q  <= cpu_reset_d;
      cpu_cycles_q <= cpu_cycles_d;
    end
  end

  assign cpu_clken  = cpu_clken_q;
  assign cpu_reset  = cpu_reset_q;
  assign cpu_cycles = cpu_cycles_q;

endmodule

// File: tb/tb_cpu_sys_ctrl.sv
// Scoreboard testbench for cpu_sys_ctrl. A stimulus process drives inputs and
// pushes the reference model's expected outputs for each clock into a queue.
// A monitor process pops and compares them after every rising edge.
module tb_cpu_sys_ctrl;

  localparam int CLK_DIV    = 25;
  localparam int RST_CYCLES = 63;
  localparam int CNT_W      = 32;

  logic             clk25;
  logic             reset, soft_reset, turbo, hold, step_mode, step;
  logic             cpu_clken, cpu_reset;
  logic [CNT_W-1:0] cpu_cycles;

  cpu_sys_ctrl #(.CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
    .clk25      (clk25),
    .reset      (reset),
    .soft_reset (soft_reset),
    .turbo      (turbo),
    .hold       (hold),
    .step_mode  (step_mode),
    .step       (step),
    .cpu_clken  (cpu_clken),
    .cpu_reset  (cpu_reset),
    .cpu_cycles (cpu_cycles)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  typedef struct {
    logic             clken;
    logic             rst;
    logic [CNT_W-1:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, expressed in absolute clock numbers and pulse counts.
  longint           t = 0;         // index of the clock currently being driven
  longint           next_opp = 1;  // clock at which the next enable may occur
  int               m_pulses = 0;  // enables since the last (soft) reset, saturating
  logic             m_clken = 1'b0;
  logic             m_rst = 1'b1;
  logic [CNT_W-1:0] m_cycles = '0;
  logic             m_pend = 1'b0;
  logic             m_step_prev = 1'b0;

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at clock %0d: got %0d expected %0d", name, t, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk25);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_clken",  CNT_W'(cpu_clken), CNT_W'(e.clken));
        chk("cpu_reset",  CNT_W'(cpu_reset), CNT_W'(e.rst));
        chk("cpu_cycles", cpu_cycles,        e.cyc);
      end
    end
  end

  // Drive one clock of inputs, advance the model, queue the expected outputs.
  task automatic cyc(input logic r, input logic sr, input logic tu,
                     input logic h, input logic sm, input logic st);
    logic             tick;
    logic             ok;
    logic [CNT_W-1:0] new_cycles;
    exp_t             e;
    reset = r; soft_reset = sr; turbo = tu; hold = h; step_mode = sm; step = st;
    if (r) begin
      m_clken = 1'b0; m_rst = 1'b1; m_cycles = '0; m_pulses = 0;
      next_opp = t + 1; m_pend = 1'b0; m_step_prev = 1'b0;
    end else begin
      ok = 1'b1;
`ifdef SINGLE_STEP_EN
      ok = !sm || m_rst || m_pend;
      if (st && !m_step_prev) m_pend = 1'b1;
      else if ((t == next_opp) && !h && ok) m_pend = 1'b0;
      m_step_prev = st;
`endif
      tick = (t == next_opp) && !h && ok;
      new_cycles = sr ? '0 : ((m_clken && !m_rst) ? m_cycles + 1'b1 : m_cycles);
      if (t == next_opp) next_opp = tick ? t + (tu ? 1 : CLK_DIV) : t + 1;
      if (sr) begin
        m_pulses = 0;
        m_rst    = 1'b1;
      end else if (tick) begin
        if (m_pulses <= RST_CYCLES) m_pulses++;
        m_rst = (m_pulses <= RST_CYCLES);
      end
      m_clken  = tick;
      m_cycles = new_cycles;
    end
    e.clken = m_clken; e.rst = m_rst; e.cyc = m_cycles;
    exp_q.push_back(e);
    @(negedge clk25);
    t++;
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at clock %0d (got timeout expected event)", name, t);
  endtask

  initial begin
    int n;
    logic tu_r, sm_r, st_r;
    reset = 1'b1; soft_reset = 1'b0; turbo = 1'b0; hold = 1'b0; step_mode = 1'b0; step = 1'b0;

    // Reset, then the free-running power-up sequence until 100 counted cycles.
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0);
    n = 0;
    while (m_cycles != 100 && n < 6000) begin cyc(0, 0, 0, 0, 0, 0); n++; end
    if (m_cycles != 100) bound_fail("reach_cycles_100");

    // Soft reset and a full second reset sequence.
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 75 * CLK_DIV; k++) cyc(0, 0, 0, 0, 0, 0);

    // Turbo raised mid-period, then lowered again.
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 120; k++) cyc(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 80; k++) cyc(0, 0, 0, 0, 0, 0);

    // Hold for 10 clocks starting 3 clocks before a boundary.
    n = 0;
    while (next_opp - t != 3 && n < 100) begin cyc(0, 0, 0, 0, 0, 0); n++; end
    if (next_opp - t != 3) bound_fail("hold_align");
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 0, 0);
    // Hold only away from the boundary: no effect on spacing.
    for (int k = 0; k < 80; k++) cyc(0, 0, 0, (t != next_opp), 0, 0);

    // Soft reset coincident with an enable opportunity.
    n = 0;
    while (t != next_opp && n < 100) begin cyc(0, 0, 0, 0, 0, 0); n++; end
    if (t != next_opp) bound_fail("soft_on_tick_align");
    cyc(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 60; k++) cyc(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-period.
    n = 0;
    while (next_opp - t != 10 && n < 100) begin cyc(0, 0, 0, 0, 0, 0); n++; end
    if (next_opp - t != 10) bound_fail("reset_mid_align");
    cyc(1, 1, 1, 1, 1, 1);
    for (int k = 0; k < 70 * CLK_DIV; k++) cyc(0, 0, 0, 0, 0, 0);

    // Step mode with single and doubled step edges.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 60; j++) cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1, 0);
      if (k == 2) begin cyc(0, 0, 0, 0, 1, 1); cyc(0, 0, 0, 0, 1, 0); end
    end
    for (int j = 0; j < 60; j++) cyc(0, 0, 0, 0, 1, 0);

    // Randomised mix of all controls.
    tu_r = 1'b0; sm_r = 1'b0; st_r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 60) == 0) tu_r = ~tu_r;
      if ($urandom_range(0, 200) == 0) sm_r = ~sm_r;
      if ($urandom_range(0, 15) == 0) st_r = ~st_r;
      cyc(($urandom_range(0, 1500) == 0), ($urandom_range(0, 400) == 0), tu_r,
          ($urandom_range(0, 4) == 0), sm_r, st_r);
    end

    // Drain the scoreboard.
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk25);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
